mem_access_ctrl: RTL

Memory-stage access controller sitting directly upstream of `lsu`. It accepts one load/store request at a time from the pipeline and converts byte/half/word accesses into word-aligned `lsu` transactions with byte-lane masks. Misaligned accesses are split into two `lsu` beats, or rejected, depending on a parameter. Load data is realigned and sign- or zero-extended before it is returned to the pipeline.

---
 rtl/mem_access_ctrl.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage access controller placed in front of the lsu. It takes one
// byte/half/word load or store from the pipeline at a time and turns it into
// word-aligned lsu transactions with byte-lane masks. An access that crosses
// a word boundary is either split into two lsu beats (SPLIT_MISALIGNED=1) or
// rejected with err_o (SPLIT_MISALIGNED=0). Load data is realigned and sign-
// or zero-extended before it is handed back.
//
// Ports
//   clk_i, rst_i        clock (rising edge) and synchronous active-high reset
//   req_i               request valid, taken only while ready_o=1
//   we_i                1 = store, 0 = load
//   size_i              00 byte, 01 half, 10 word, 11 illegal
//   unsigned_i          zero-extend load data when 1
//   addr_i, wdata_i     byte address and right-aligned store value
//   ready_o             idle and able to accept a request
//   done_o, err_o       completion pulse, error flag (pulses with done_o)
//   rdata_o             extended load data, valid while done_o=1
//   lsu_read_o/_write_o read / write strobe to the lsu
//   lsu_we_o            byte-lane mask to the lsu
//   lsu_addr_o          word-aligned lsu address
//   lsu_data_o          lane-positioned store data
//   lsu_data_i          read word from the lsu
//   lsu_valid_i         lsu transaction complete
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter logic SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        lsu_read_o,
    output logic        lsu_write_o,
    output logic [3:0]  lsu_we_o,
    output logic [31:0] lsu_addr_o,
    output logic [31:0] lsu_data_o,
    input  logic [31:0] lsu_data_i,
    input  logic        lsu_valid_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_GAP   = 2'd2,
        ST_BEAT1 = 2'd3
    } state_t;

    state_t r_state, w_state_next;

    // Registered outputs
    logic        r_ready,      w_ready_next;
    logic        r_done,       w_done_next;
    logic        r_err,        w_err_next;
    logic [31:0] r_rdata,      w_rdata_next;
    logic        r_lsu_read,   w_lsu_read_next;
    logic        r_lsu_write,  w_lsu_write_next;
    logic [3:0]  r_lsu_we,     w_lsu_we_next;
    logic [31:0] r_lsu_addr,   w_lsu_addr_next;
    logic [31:0] r_lsu_data,   w_lsu_data_next;

    // Captured request context
    logic        r_we,         w_we_next;
    logic [1:0]  r_size,       w_size_next;
    logic        r_unsigned,   w_unsigned_next;
    logic [1:0]  r_off,        w_off_next;
    logic        r_split,      w_split_next;
    logic [31:0] r_data_hi,    w_data_hi_next;
    logic [3:0]  r_mask_hi,    w_mask_hi_next;
    logic [31:0] r_word0,      w_word0_next;

    // Request decode, evaluated on the incoming request
    logic [1:0]  w_off;
    logic [3:0]  w_base;
    logic [7:0]  w_mask8;
    logic        w_split;
    logic        w_reject;
    logic        w_accept;
    logic [63:0] w_wdata_sh;

    assign w_off = addr_i[1:0];

    always_comb begin
        case (size_i)
            2'b00:   w_base = 4'b0001;
            2'b01:   w_base = 4'b0011;
            default: w_base = 4'b1111;
        endcase
    end

    // Lanes above bit 3 of the 8-lane mask belong to the following word.
    assign w_mask8    = {4'b0000, w_base} << w_off;
    assign w_split    = |w_mask8[7:4];
    assign w_reject   = (size_i == 2'b11) || (w_split && !SPLIT_MISALIGNED);
    assign w_accept   = req_i && r_ready;
    assign w_wdata_sh = {32'h0, wdata_i} << {w_off, 3'b000};

    // Realign the merged {beat1, beat0} words and extend to 32 bits.
    function automatic logic [31:0] extend_load(
        input logic [63:0] merged,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [63:0] sh;
        sh = merged >> {off, 3'b000};
        case (size)
            2'b00:   extend_load = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   extend_load = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: extend_load = sh[31:0];
        endcase
    endfunction

    always_comb begin
        w_state_next     = r_state;
        w_ready_next     = r_ready;
        w_done_next      = 1'b0;
        w_err_next       = 1'b0;
        w_rdata_next     = 32'h0;
        w_lsu_read_next  = r_lsu_read;
        w_lsu_write_next = r_lsu_write;
        w_lsu_we_next    = r_lsu_we;
        w_lsu_addr_next  = r_lsu_addr;
        w_lsu_data_next  = r_lsu_data;
        w_we_next        = r_we;
        w_size_next      = r_size;
        w_unsigned_next  = r_unsigned;
        w_off_next       = r_off;
        w_split_next     = r_split;
        w_data_hi_next   = r_data_hi;
        w_mask_hi_next   = r_mask_hi;
        w_word0_next     = r_word0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_reject) begin
                        // Rejected requests never reach the lsu; controller stays idle.
                        w_done_next = 1'b1;
                        w_err_next  = 1'b1;
                    end else begin
                        w_state_next     = ST_BEAT0;
                        w_ready_next     = 1'b0;
                        w_lsu_read_next  = !we_i;
                        w_lsu_write_next = we_i;
                        w_lsu_addr_next  = {addr_i[31:2], 2'b00};
                        w_lsu_data_next  = we_i ? w_wdata_sh[31:0] : 32'h0;
                        w_lsu_we_next    = we_i ? w_mask8[3:0] : 4'b0000;
                        w_we_next        = we_i;
                        w_size_next      = size_i;
                        w_unsigned_next  = unsigned_i;
                        w_off_next       = w_off;
                        w_split_next     = w_split;
                        w_data_hi_next   = w_wdata_sh[63:32];
                        w_mask_hi_next   = w_mask8[7:4];
                    end
                end
            end

            ST_BEAT0: begin
                if (lsu_valid_i) begin
                    w_lsu_read_next  = 1'b0;
                    w_lsu_write_next = 1'b0;
                    w_word0_next     = lsu_data_i;
                    if (r_split) begin
                        w_state_next = ST_GAP;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_ready_next = 1'b1;
                        w_done_next  = 1'b1;
                        w_rdata_next = r_we ? 32'h0
                                            : extend_load({32'h0, lsu_data_i}, r_off, r_size, r_unsigned);
                    end
                end
            end

            // One idle cycle so the lsu always sees strobes drop between beats.
            ST_GAP: begin
                w_state_next     = ST_BEAT1;
                w_lsu_read_next  = !r_we;
                w_lsu_write_next = r_we;
                w_lsu_addr_next  = r_lsu_addr + 32'd4;
                w_lsu_data_next  = r_we ? r_data_hi : 32'h0;
                w_lsu_we_next    = r_we ? r_mask_hi : 4'b0000;
            end

            ST_BEAT1: begin
                if (lsu_valid_i) begin
                    w_state_next     = ST_IDLE;
                    w_ready_next     = 1'b1;
                    w_done_next      = 1'b1;
                    w_lsu_read_next  = 1'b0;
                    w_lsu_write_next = 1'b0;
                    w_rdata_next     = r_we ? 32'h0
                                            : extend_load({lsu_data_i, r_word0}, r_off, r_size, r_unsigned);
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= 32'h0;
            r_lsu_read  <= 1'b0;
            r_lsu_write <= 1'b0;
            r_lsu_we    <= 4'b0000;
            r_lsu_addr  <= 32'h0;
            r_lsu_data  <= 32'h0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_off       <= 2'b00;
            r_split     <= 1'b0;
            r_data_hi   <= 32'h0;
            r_mask_hi   <= 4'b0000;
            r_word0     <= 32'h0;
        end else begin
            r_state     <= w_state_next;
            r_ready     <= w_ready_next;
            r_done      <= w_done_next;
            r_err       <= w_err_next;
            r_rdata     <= w_rdata_next;
            r_lsu_read  <= w_lsu_read_next;
            r_lsu_write <= w_lsu_write_next;
            r_lsu_we    <= w_lsu_we_next;
            r_lsu_addr  <= w_lsu_addr_next;
            r_lsu_data  <= w_lsu_data_next;
            r_we        <= w_we_next;
            r_size      <= w_size_next;
            r_unsigned  <= w_unsigned_next;
            r_off       <= w_off_next;
            r_split     <= w_split_next;
            r_data_hi   <= w_data_hi_next;
            r_mask_hi   <= w_mask_hi_next;
            r_word0     <= w_word0_next;
        end
    end

    assign ready_o     = r_ready;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign lsu_read_o  = r_lsu_read;
    assign lsu_write_o = r_lsu_write;
    assign lsu_we_o    = r_lsu_we;
    assign lsu_addr_o  = r_lsu_addr;
    assign lsu_data_o  = r_lsu_data;

endmodule
